// File: rtl/spi_tx_sched.sv
// SPI mode-0 frame scheduler: pops i_len bytes from a byte FIFO under one chip-select,
// shifting each out MSB-first and returning the byte received during each transfer.
module spi_tx_sched #(
    parameter int LEN_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_abort,
    input  logic             i_fifo_empty,
    input  logic [7:0]       i_fifo_data,
    output logic             o_fifo_rd,
    output logic             o_sclk,
    output logic             o_mosi,
    input  logic             i_miso,
    output logic             o_cs_n,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remain_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [2:0]       bit_q;
    logic [6:0]       tx_q;
    logic [7:0]       rx_q;
    logic             phase_last;
    logic             abort_now;
    logic             start_ok;

    assign phase_last = (phase_q == div_q);
    assign abort_now  = i_abort && (state_q != S_IDLE);
    assign start_ok   = i_start && (i_len != '0);
    assign o_busy     = (state_q != S_IDLE);
    assign o_stall    = (state_q == S_LOAD) && !o_cs_n && i_fifo_empty;

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        state_d   = state_q;
        o_fifo_rd = 1'b0;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_LOAD;
            S_LOAD: begin
                if (!i_fifo_empty) begin
                    o_fifo_rd = 1'b1;
                    state_d   = S_LOW;
                end
            end
            S_LOW:    if (phase_last) state_d = S_HIGH;
            S_HIGH: begin
                if (phase_last) begin
                    if (bit_q != 3'd0)                state_d = S_LOW;
                    else if (remain_q == LEN_W'(1))   state_d = S_FINISH;
                    else                              state_d = S_LOAD;
                end
            end
            S_FINISH: if (phase_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a pop that would otherwise happen this cycle.
        if (abort_now) begin
            state_d   = S_IDLE;
            o_fifo_rd = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // NOTE: registers use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            remain_q   <= '0;
            div_q      <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            o_sclk     <= 1'b0;
            o_mosi     <= 1'b0;
            o_cs_n     <= 1'b1;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            o_done     <= 1'b0;
            if (abort_now) begin
                o_cs_n  <= 1'b1;
                o_sclk  <= 1'b0;
                phase_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_ok) begin
                            remain_q <= i_len;
                            div_q    <= i_div;
                            phase_q  <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (!i_fifo_empty) begin
                            tx_q    <= i_fifo_data[6:0];
                            o_mosi  <= i_fifo_data[7];
                            bit_q   <= 3'd7;
                            o_cs_n  <= 1'b0;
                            phase_q <= '0;
                        end
                    end
                    S_LOW: begin
                        if (phase_last) begin
                            o_sclk  <= 1'b1;
                            rx_q    <= {rx_q[6:0], i_miso};
                            phase_q <= '0;
                        end else begin
                            phase_q <= phase_q + DIV_W'(1);
                        end
                    end
                    S_HIGH: begin
                        if (phase_last) begin
                            o_sclk  <= 1'b0;
                            phase_q <= '0;
                            if (bit_q != 3'd0) begin
                                o_mosi <= tx_q[6];
                                tx_q   <= {tx_q[5:0], 1'b0};
                                bit_q  <= bit_q - 3'd1;
                            end else begin
                                o_rx_data  <= rx_q;
                                o_rx_valid <= 1'b1;
                                remain_q   <= remain_q - LEN_W'(1);
                            end
                        end else begin
                            phase_q <= phase_q + DIV_W'(1);
                        end
                    end
                    S_FINISH: begin
                        if (phase_last) begin
                            o_cs_n <= 1'b1;
                            o_done <= 1'b1;
                        end else begin
                            phase_q <= phase_q + DIV_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_sched.sv
// Self-checking bench for spi_tx_sched: FIFO model, MISO loopback, passive monitor and
// frame-level expectations derived from byte counts and the divider.
module tb_spi_tx_sched;

    logic       i_clk;
    logic       i_reset_n = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_len = '0;
    logic [7:0] i_div = '0;
    logic       i_abort = 1'b0;
    logic       i_fifo_empty;
    logic [7:0] i_fifo_data;
    logic       o_fifo_rd;
    logic       o_sclk;
    logic       o_mosi;
    logic       i_miso;
    logic       o_cs_n;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_busy;
    logic       o_stall;
    logic       o_done;

    spi_tx_sched #(.LEN_W(8), .DIV_W(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_len(i_len),
        .i_div(i_div), .i_abort(i_abort), .i_fifo_empty(i_fifo_empty),
        .i_fifo_data(i_fifo_data), .o_fifo_rd(o_fifo_rd), .o_sclk(o_sclk),
        .o_mosi(o_mosi), .i_miso(i_miso), .o_cs_n(o_cs_n), .o_rx_data(o_rx_data),
        .o_rx_valid(o_rx_valid), .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- FIFO model (pop happens on the clock edge that sees o_fifo_rd) -------
    logic [7:0] fifo_mem [256];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    bit         flush = 1'b0;
    int         empty_pop = 0;

    assign i_fifo_empty = (rd_ptr == wr_ptr);
    assign i_fifo_data  = fifo_mem[rd_ptr];

    always @(posedge i_clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (o_fifo_rd) begin
            rd_ptr <= rd_ptr + 8'd1;
            if (i_fifo_empty) empty_pop <= empty_pop + 1;
        end
    end

    bit miso_inv = 1'b0;
    assign i_miso = o_mosi ^ miso_inv;

    // ---------------- passive monitor, sampled on the falling edge ----------------
    int   cur_h = 1;
    logic [7:0] rx_log [$];
    bit   mosi_log [$];
    int   done_cnt = 0, done_bad = 0, cs_low_cnt = 0, stall_cnt = 0, stall_bad = 0;
    int   hi_run = 0, hi_bad = 0;
    logic prev_sclk = 1'b0, prev_cs_n = 1'b1;

    always @(negedge i_clk) begin
        if (o_rx_valid) rx_log.push_back(o_rx_data);
        if (o_sclk && !prev_sclk) mosi_log.push_back(o_mosi);
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            if (!(o_cs_n && !prev_cs_n)) done_bad <= done_bad + 1;
        end
        if (!o_cs_n) cs_low_cnt <= cs_low_cnt + 1;
        if (o_stall) begin
            stall_cnt <= stall_cnt + 1;
            if (o_cs_n || o_sclk) stall_bad <= stall_bad + 1;
        end
        if (o_sclk) hi_run <= hi_run + 1;
        else begin
            if (prev_sclk && hi_run != cur_h) hi_bad <= hi_bad + 1;
            hi_run <= 0;
        end
        prev_sclk <= o_sclk;
        prev_cs_n <= o_cs_n;
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] fd [16];
    int b_rx, b_mo, b_dn, b_db, b_cs, b_hb, b_ep, b_st, b_sb;
    logic [7:0] b_rd;

    task automatic snap();
        b_rx = rx_log.size();  b_mo = mosi_log.size(); b_dn = done_cnt; b_db = done_bad;
        b_cs = cs_low_cnt;     b_hb = hi_bad;          b_ep = empty_pop; b_rd = rd_ptr;
        b_st = stall_cnt;      b_sb = stall_bad;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_flush();
        @(negedge i_clk) flush = 1'b1;
        @(negedge i_clk) flush = 1'b0;
    endtask

    task automatic start_frame(input int len, input int div);
        @(negedge i_clk);
        i_start = 1'b1; i_len = 8'(len); i_div = 8'(div);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Waits for the frame to end while scrambling i_div/i_len/i_start, which must not matter.
    task automatic wait_idle(input string tag);
        int k = 0;
        while (o_busy && k < 4000) begin
            i_div = 8'($urandom); i_len = 8'($urandom); i_start = 1'($urandom);
            @(negedge i_clk);
            k++;
        end
        i_start = 1'b0; i_len = '0; i_div = '0;
        check({tag, "_timeout"}, 32'(k < 4000), 32'd1);
        @(negedge i_clk);
    endtask

    // Expected CS-low length for an unstalled frame of n bytes with half-period h.
    function automatic int cs_len(input int n, input int h);
        return n * 16 * h + (n - 1) + h;
    endfunction

    task automatic check_frame(input string tag, input int len, input bit inv, input int exp_cs);
        logic [7:0] b;
        check({tag, "_pops"},      32'(8'(rd_ptr - b_rd)), 32'(len));
        check({tag, "_empty_pop"}, 32'(empty_pop - b_ep), 32'd0);
        check({tag, "_done"},      32'(done_cnt - b_dn), 32'd1);
        check({tag, "_done_edge"}, 32'(done_bad - b_db), 32'd0);
        check({tag, "_cs_low"},    32'(cs_low_cnt - b_cs), 32'(exp_cs));
        check({tag, "_sclk_high"}, 32'(hi_bad - b_hb), 32'd0);
        check({tag, "_rx_count"},  32'(rx_log.size() - b_rx), 32'(len));
        check({tag, "_mosi_bits"}, 32'(mosi_log.size() - b_mo), 32'(8 * len));
        for (int k = 0; k < len; k++) begin
            if (b_rx + k < rx_log.size())
                check({tag, "_rx"}, 32'(rx_log[b_rx + k]), 32'(fd[k] ^ {8{inv}}));
            if (b_mo + 8 * k + 7 < mosi_log.size()) begin
                b = '0;
                for (int j = 0; j < 8; j++) b = {b[6:0], mosi_log[b_mo + 8 * k + j]};
                check({tag, "_mosi"}, 32'(b), 32'(fd[k]));
            end
        end
    endtask

    task automatic run_frame(input string tag, input int len, input int div, input bit inv,
                             input int exp_cs);
        for (int k = 0; k < len; k++) push(fd[k]);
        miso_inv = inv;
        cur_h    = div + 1;
        snap();
        start_frame(len, div);
        wait_idle(tag);
        check_frame(tag, len, inv, exp_cs);
    endtask

    typedef struct {
        int         len;
        int         div;
        bit         inv;
        logic [7:0] d0, d1, d2;
        int         exp_cs;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int busy_seen;

        // ---- asynchronous reset, no clock edge yet ----
        #1 i_reset_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(o_cs_n), 32'd1);
        check("rst_sclk", 32'(o_sclk), 32'd0);
        check("rst_mosi", 32'(o_mosi), 32'd0);
        check("rst_rx_data", 32'(o_rx_data), 32'd0);
        check("rst_rx_valid", 32'(o_rx_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_fifo_rd", 32'(o_fifo_rd), 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // ---- table-driven frames ----
        tbl[0] = '{2, 0, 1'b0, 8'hA5, 8'h3C, 8'h00, 34};
        tbl[1] = '{1, 3, 1'b0, 8'h81, 8'h00, 8'h00, 68};
        tbl[2] = '{3, 1, 1'b1, 8'hF0, 8'h0F, 8'h5A, 100};
        tbl[3] = '{1, 0, 1'b1, 8'hFF, 8'h00, 8'h00, 17};
        for (int v = 0; v < 4; v++) begin
            fd[0] = tbl[v].d0; fd[1] = tbl[v].d1; fd[2] = tbl[v].d2;
            run_frame($sformatf("vec%0d", v), tbl[v].len, tbl[v].div, tbl[v].inv, tbl[v].exp_cs);
        end

        // ---- stall: second byte arrives ten cycles after the first byte ends ----
        push(8'hA5);
        fd[0] = 8'hA5; fd[1] = 8'h3C;
        miso_inv = 1'b0; cur_h = 1;
        snap();
        start_frame(2, 0);
        k = 0;
        while (!o_stall && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check("stall_seen", 32'(o_stall), 32'd1);
        repeat (9) @(negedge i_clk);
        @(posedge i_clk);
        #1 push(8'h3C);
        wait_idle("stall");
        check("stall_cycles", 32'(stall_cnt - b_st), 32'd10);
        check("stall_pins", 32'(stall_bad - b_sb), 32'd0);
        check_frame("stall", 2, 1'b0, 44);

        // ---- ignored request: i_len == 0 ----
        snap();
        @(negedge i_clk);
        i_start = 1'b1; i_len = '0; i_div = 8'd2;
        busy_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_busy || !o_cs_n) busy_seen++;
        end
        check("len0_busy", 32'(busy_seen), 32'd0);
        check("len0_pops", 32'(8'(rd_ptr - b_rd)), 32'd0);

        // ---- abort during bit 4 of byte 2 ----
        push(8'h11); push(8'h22); push(8'h33);
        miso_inv = 1'b0; cur_h = 1;
        snap();
        start_frame(3, 0);
        k = 0;
        while ((mosi_log.size() - b_mo) < 12 && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        check("abort_reach", 32'(k < 500), 32'd1);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_cs_n", 32'(o_cs_n), 32'd1);
        check("abort_sclk", 32'(o_sclk), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_stall", 32'(o_stall), 32'd0);
        repeat (6) @(negedge i_clk);
        check("abort_pops", 32'(8'(rd_ptr - b_rd)), 32'd2);
        check("abort_rx_count", 32'(rx_log.size() - b_rx), 32'd1);
        if (rx_log.size() > b_rx) check("abort_rx", 32'(rx_log[b_rx]), 32'h11);
        check("abort_done", 32'(done_cnt - b_dn), 32'd0);
        check("abort_left", 32'(8'(wr_ptr - rd_ptr)), 32'd1);
        check("abort_head", 32'(i_fifo_data), 32'h33);
        do_flush();

        // ---- abort in the same cycle as a pop: no pop may happen ----
        push(8'h44); push(8'h55);
        snap();
        start_frame(2, 0);
        k = 0;
        while (!o_fifo_rd && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        check("abort_load_seen", 32'(o_fifo_rd), 32'd1);
        i_abort = 1'b1;
        #1 check("abort_gates_pop", 32'(o_fifo_rd), 32'd0);
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_load_busy", 32'(o_busy), 32'd0);
        check("abort_load_cs_n", 32'(o_cs_n), 32'd1);
        check("abort_load_pops", 32'(8'(rd_ptr - b_rd)), 32'd0);
        do_flush();

        // ---- asynchronous reset mid-frame, then a normal frame ----
        push(8'h66); push(8'h77);
        cur_h = 2;
        snap();
        start_frame(2, 1);
        k = 0;
        while ((mosi_log.size() - b_mo) < 5 && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        check("arst_cs_n", 32'(o_cs_n), 32'd1);
        check("arst_sclk", 32'(o_sclk), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        do_flush();
        fd[0] = 8'h66; fd[1] = 8'h77;
        run_frame("after_rst", 2, 1, 1'b0, cs_len(2, 2));

        // ---- randomized frames against the arithmetic frame model ----
        for (int r = 0; r < 12; r++) begin
            int len, div;
            bit inv;
            len = 1 + int'($urandom_range(3));
            div = int'($urandom_range(3));
            inv = 1'($urandom);
            for (int j = 0; j < len; j++) fd[j] = 8'($urandom);
            run_frame($sformatf("rnd%0d", r), len, div, inv, cs_len(len, div + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
